// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int NREQ_DEF    = 3;
  localparam int AW_DEF      = 32;
  localparam int DW_DEF      = 32;
  localparam int BE_W        = 4;
  localparam int TIMEOUT_DEF = 1024;

  localparam logic [31:0] CNT_SAT = 32'hFFFF_FFFF;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == CNT_SAT) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Round-robin winner selection with an optional lock favouring requester 0.
module rr_pick #(
  parameter int NREQ = 3,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   last_grant,
  input  logic            lock,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   winner,
  output logic            any_valid
);

  // Scan from the farthest candidate back to the nearest so the nearest valid one after last_grant is kept.
  always_comb begin
    int cand;
    grant     = '0;
    winner    = '0;
    cand      = 0;
    any_valid = |valid;
    if (lock && valid[0]) begin
      grant[0] = 1'b1;
      winner   = '0;
    end else begin
      for (int off = NREQ; off >= 1; off--) begin
        cand = int'(last_grant) + off;
        if (cand >= NREQ) cand = cand - NREQ;
        if (valid[cand]) begin
          grant       = '0;
          grant[cand] = 1'b1;
          winner      = IW'(cand);
        end
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one cache access port among NREQ requesters, one access outstanding,
// with timeout abort and saturating hit/miss statistics.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*BE_W-1:0] req_be,
  input  logic                 prio_lock,
  output logic [NREQ-1:0]      req_ready,
  output logic                 req_err,
  output logic [DW-1:0]        req_rdata,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic [BE_W-1:0]      mem_be,
  input  logic [DW-1:0]        mem_rdata,
  input  logic                 mem_done,
  input  logic                 mem_hit,
  input  logic                 clr_stats,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  // Unpacked views of the packed request buses, indexed by requester.
  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic [BE_W-1:0] be_arr    [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
      assign be_arr[gi]    = req_be[gi*BE_W +: BE_W];
    end
  endgenerate

  arb_state_t      state_reg, state_next;
  logic [IW-1:0]   last_grant_reg, last_grant_next;
  logic [TW-1:0]   to_cnt_reg, to_cnt_next;
  logic            mem_ren_reg, mem_ren_next;
  logic            mem_wen_reg, mem_wen_next;
  logic [AW-1:0]   mem_addr_reg, mem_addr_next;
  logic [DW-1:0]   mem_wdata_reg, mem_wdata_next;
  logic [BE_W-1:0] mem_be_reg, mem_be_next;
  logic [NREQ-1:0] req_ready_reg, req_ready_next;
  logic            req_err_reg, req_err_next;
  logic [DW-1:0]   req_rdata_reg, req_rdata_next;
  logic [31:0]     hit_count_reg, miss_count_reg;
  logic            hit_inc, miss_inc;

  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant_reg),
    .lock       (prio_lock),
    .grant      (pick_grant),
    .winner     (pick_idx),
    .any_valid  (pick_any)
  );

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    to_cnt_next     = to_cnt_reg;
    mem_ren_next    = mem_ren_reg;
    mem_wen_next    = mem_wen_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    mem_be_next     = mem_be_reg;
    req_ready_next  = '0;
    req_err_next    = 1'b0;
    req_rdata_next  = req_rdata_reg;
    hit_inc         = 1'b0;
    miss_inc        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
          last_grant_next = pick_idx;
          mem_addr_next   = addr_arr[pick_idx];
          mem_wdata_next  = wdata_arr[pick_idx];
          mem_be_next     = be_arr[pick_idx];
          mem_ren_next    = !(|(req_we & pick_grant));
          mem_wen_next    = |(req_we & pick_grant);
          to_cnt_next     = '0;
          state_next      = BUSY;
        end
      end
      BUSY: begin
        // Completion takes precedence over a timeout reached in the same cycle.
        if (mem_done) begin
          req_rdata_next                 = mem_rdata;
          mem_ren_next                   = 1'b0;
          mem_wen_next                   = 1'b0;
          req_ready_next[last_grant_reg] = 1'b1;
          hit_inc                        = mem_hit;
          miss_inc                       = !mem_hit;
          state_next                     = RESP;
        end else if (to_cnt_reg == TW'(TIMEOUT - 1)) begin
          mem_ren_next                   = 1'b0;
          mem_wen_next                   = 1'b0;
          req_ready_next[last_grant_reg] = 1'b1;
          req_err_next                   = 1'b1;
          state_next                     = RESP;
        end else begin
          to_cnt_next = to_cnt_reg + TW'(1);
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and access-field registers; reset drops strobes immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= IW'(NREQ - 1);
      to_cnt_reg     <= '0;
      mem_ren_reg    <= 1'b0;
      mem_wen_reg    <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      mem_be_reg     <= '0;
      req_ready_reg  <= '0;
      req_err_reg    <= 1'b0;
      req_rdata_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      to_cnt_reg     <= to_cnt_next;
      mem_ren_reg    <= mem_ren_next;
      mem_wen_reg    <= mem_wen_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      mem_be_reg     <= mem_be_next;
      req_ready_reg  <= req_ready_next;
      req_err_reg    <= req_err_next;
      req_rdata_reg  <= req_rdata_next;
    end
  end

  // Saturating hit/miss counters; a clear overrides any coincident increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else if (clr_stats) begin
      hit_count_reg  <= '0;
      miss_count_reg <= '0;
    end else begin
      if (hit_inc)  hit_count_reg  <= sat_inc(hit_count_reg);
      if (miss_inc) miss_count_reg <= sat_inc(miss_count_reg);
    end
  end

  assign mem_ren    = mem_ren_reg;
  assign mem_wen    = mem_wen_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign mem_be     = mem_be_reg;
  assign req_ready  = req_ready_reg;
  assign req_err    = req_err_reg;
  assign req_rdata  = req_rdata_reg;
  assign hit_count  = hit_count_reg;
  assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios then random traffic
// checked against a simple arbitration/statistics model.
module tb_mem_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int TO   = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid, req_we;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ*4-1:0] req_be;
  logic              prio_lock;
  logic [NREQ-1:0]   req_ready;
  logic              req_err;
  logic [DW-1:0]     req_rdata;
  logic              mem_ren, mem_wen;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [3:0]        mem_be;
  logic [DW-1:0]     mem_rdata;
  logic              mem_done, mem_hit, clr_stats;
  logic [31:0]       hit_count, miss_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [31:0] m_addr [NREQ];
  logic        m_we   [NREQ];
  logic [31:0] m_wd   [NREQ];
  logic [3:0]  m_be   [NREQ];
  logic [31:0] m_hit, m_miss;
  int          m_last;

  mem_port_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_be(req_be), .prio_lock(prio_lock),
    .req_ready(req_ready), .req_err(req_err), .req_rdata(req_rdata),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_done(mem_done), .mem_hit(mem_hit), .clr_stats(clr_stats),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] v, input logic lock, input int last);
    if (lock && v[0]) return 0;
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic we,
                         input logic [31:0] wd, input logic [3:0] be);
    m_addr[i] = a; m_we[i] = we; m_wd[i] = wd; m_be[i] = be;
    req_addr[i*AW +: AW]  = a;
    req_we[i]             = we;
    req_wdata[i*DW +: DW] = wd;
    req_be[i*4 +: 4]      = be;
  endtask

  // One access: called at an IDLE-cycle negedge with valids already set.
  task automatic txn(input int lat, input logic hit, input logic [31:0] rd,
                     input bit tmo, input bit clr, input bit keep, output int w);
    int exp_w, n;
    w = -1;
    exp_w = model_pick(req_valid, prio_lock, m_last);
    n = 0;
    while (!(mem_ren | mem_wen) && n < 40) begin @(negedge clk); n++; end
    chk("strobe_seen", 32'(n < 40), 32'd1);
    if (n >= 40) return;
    chk("mem_addr", mem_addr, m_addr[exp_w]);
    chk("mem_wen", 32'(mem_wen), 32'(m_we[exp_w]));
    chk("mem_ren", 32'(mem_ren), 32'(!m_we[exp_w]));
    chk("mem_wdata", mem_wdata, m_wd[exp_w]);
    chk("mem_be", 32'(mem_be), 32'(m_be[exp_w]));
    m_last = exp_w;
    if (tmo) begin
      n = 1;
      @(negedge clk);
      while ((mem_ren | mem_wen) && n < 100) begin n++; @(negedge clk); end
      chk("busy_cycles", 32'(n), 32'(TO));
      chk("err_on_tmo", 32'(req_err), 32'd1);
    end else begin
      repeat (lat) begin
        @(negedge clk);
        chk("ready_early", 32'(req_ready), 32'd0);
      end
      mem_done = 1'b1; mem_hit = hit; mem_rdata = rd; clr_stats = clr;
      @(negedge clk);
      mem_done = 1'b0; clr_stats = 1'b0;
      if (clr) begin m_hit = 0; m_miss = 0; end
      else if (hit) m_hit = sat_add(m_hit);
      else m_miss = sat_add(m_miss);
      chk("req_err", 32'(req_err), 32'd0);
      chk("req_rdata", req_rdata, rd);
      chk("strobe_drop", 32'(mem_ren | mem_wen), 32'd0);
    end
    chk("ready_vec", 32'(req_ready), 32'(1 << exp_w));
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) w = i;
    chk("winner", 32'(w), 32'(exp_w));
    chk("hit_count", hit_count, m_hit);
    chk("miss_count", miss_count, m_miss);
    if (!keep) req_valid[exp_w] = 1'b0;
    @(negedge clk);
    chk("ready_width", 32'(req_ready), 32'd0);
    chk("err_width", 32'(req_err), 32'd0);
    $display("txn winner=%0d addr=%h tmo=%0d hit=%0d hits=%0d misses=%0d",
             w, m_addr[exp_w], tmo, hit, hit_count, miss_count);
  endtask

  initial begin
    int w;
    int seq [6];
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_be = '0;
    prio_lock = 1'b0; mem_rdata = '0; mem_done = 1'b0; mem_hit = 1'b0; clr_stats = 1'b0;
    m_hit = 0; m_miss = 0; m_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h100 * (i + 1), 1'b0, 32'h0, 4'hF);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_ren", 32'(mem_ren), 0);
    chk("rst_wen", 32'(mem_wen), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_be", 32'(mem_be), 0);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_err", 32'(req_err), 0);
    chk("rst_rdata", req_rdata, 0);
    chk("rst_hit", hit_count, 0);
    chk("rst_miss", miss_count, 0);

    // Single read from requester 1 at 0x14
    set_req(1, 32'h14, 1'b0, 32'h0, 4'hF);
    req_valid = 3'b010;
    txn(2, 1'b1, 32'hDEADBEEF, 0, 0, 0, w);
    chk("single_w", 32'(w), 1);
    chk("single_hit", hit_count, 1);

    // Reset, then all three valid continuously with 1-cycle cache
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    m_hit = 0; m_miss = 0; m_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h1000 + 32'(i) * 4, 1'(i), 32'hA0 + 32'(i), 4'(i + 1));
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      txn(0, 1'b1, 32'h5000 + 32'(k), 0, 0, 1, w);
      seq[k] = w;
    end
    for (int k = 0; k < 6; k++) chk("rr_order", 32'(seq[k]), 32'(k % 3));

    // prio_lock with 0 and 2 valid
    req_valid = 3'b101; prio_lock = 1'b1;
    for (int k = 0; k < 3; k++) begin
      txn(1, 1'b0, 32'h77, 0, 0, 1, w);
      chk("lock_w0", 32'(w), 0);
    end
    txn(0, 1'b1, 32'h78, 0, 0, 0, w);
    chk("lock_w0_last", 32'(w), 0);
    txn(0, 1'b1, 32'h79, 0, 0, 0, w);
    chk("lock_w2", 32'(w), 2);
    prio_lock = 1'b0;

    // Timeout
    set_req(1, 32'h2222, 1'b1, 32'h1234, 4'h3);
    req_valid = 3'b010;
    txn(0, 1'b0, 32'h0, 1, 0, 0, w);
    chk("tmo_w", 32'(w), 1);

    // Statistics: 3 hits, 2 misses, then clear with a coincident hit
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    m_hit = 0; m_miss = 0; m_last = NREQ - 1;
    for (int k = 0; k < 5; k++) begin
      req_valid = 3'b001;
      txn(k % 2, (k < 3), 32'(k), 0, 0, 0, w);
    end
    chk("stats_hit3", hit_count, 3);
    chk("stats_miss2", miss_count, 2);
    req_valid = 3'b001;
    txn(0, 1'b1, 32'h9, 0, 1, 0, w);
    chk("clr_hit", hit_count, 0);
    chk("clr_miss", miss_count, 0);

    // Saturation
    dut.hit_count_reg = 32'hFFFF_FFFF;
    m_hit = 32'hFFFF_FFFF;
    req_valid = 3'b100;
    txn(0, 1'b1, 32'hA, 0, 0, 0, w);
    chk("sat_hit", hit_count, 32'hFFFF_FFFF);

    // Random traffic
    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && ($urandom_range(0, 1) == 1)) begin
          set_req(i, $urandom, 1'($urandom), $urandom, 4'($urandom));
          req_valid[i] = 1'b1;
        end
      end
      if (req_valid == '0) begin
        set_req(k % NREQ, $urandom, 1'($urandom), $urandom, 4'($urandom));
        req_valid[k % NREQ] = 1'b1;
      end
      prio_lock = ($urandom_range(0, 3) == 0);
      txn($urandom_range(0, 3), 1'($urandom), $urandom, 0, ($urandom_range(0, 7) == 0), 0, w);
    end
    prio_lock = 1'b0;
    req_valid = '0;
    @(negedge clk);

    // Reset while BUSY
    set_req(0, 32'h3000, 1'b0, 32'h0, 4'hF);
    req_valid = 3'b001;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_ren", 32'(mem_ren), 1);
    #2 rst = 1'b1;
    #1 chk("async_ren", 32'(mem_ren), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_ready", 32'(req_ready), 0);
    end
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h4000 + 32'(i), 1'b0, 32'h0, 4'hF);
    req_valid = 3'b111;
    rst = 1'b0;
    m_hit = 0; m_miss = 0; m_last = NREQ - 1;
    txn(0, 1'b1, 32'hC0FFEE, 0, 0, 0, w);
    chk("post_rst_w", 32'(w), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
